// File: rtl/mips_pipe_core.sv
// Two-stage MIPS subset executor: S1 holds one accepted instruction, commit executes it
// against the register file and presents the whole file with a fail flag under valid/ready.
module mips_pipe_core #(
  parameter int                   DATA_W  = 16,
  parameter int                   NUM_REG = 6,
  parameter logic [NUM_REG*5-1:0] REG_MAP = {5'd16, 5'd31, 5'd23, 5'd8, 5'd18, 5'd17}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               instruction,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      instruction_fail,
  output logic [NUM_REG*DATA_W-1:0] out_regs
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;

  logic              s1_valid_q, s1_valid_d;
  logic [31:0]       s1_instr_q, s1_instr_d;
  logic              out_valid_q, out_valid_d;
  logic              fail_q, fail_d;
  logic [DATA_W-1:0] rf_q [NUM_REG];
  logic [DATA_W-1:0] rf_d [NUM_REG];

  logic              commit;
  logic              accept;
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic signed [15:0] imm_s;
  int                rs_idx, rt_idx, rd_idx, dst_idx;
  logic [DATA_W-1:0] rs_val, rt_val, result;
  logic              exec_fail;

  // Lowest matching register index wins; -1 means the code is not mapped.
  function automatic int lookup(input logic [4:0] code);
    int idx;
    idx = -1;
    for (int i = NUM_REG - 1; i >= 0; i--) begin
      if (REG_MAP[i*5 +: 5] == code) idx = i;
    end
    return idx;
  endfunction

  assign commit   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || commit;
  assign accept   = in_valid && in_ready;

  assign op    = s1_instr_q[31:26];
  assign funct = s1_instr_q[5:0];
  assign shamt = s1_instr_q[10:6];
  assign imm   = s1_instr_q[15:0];
  assign imm_s = s1_instr_q[15:0];

  always_comb begin
    rs_idx = lookup(s1_instr_q[25:21]);
    rt_idx = lookup(s1_instr_q[20:16]);
    rd_idx = lookup(s1_instr_q[15:11]);
    rs_val = '0;
    rt_val = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (rs_idx == i) rs_val = rf_q[i];
      if (rt_idx == i) rt_val = rf_q[i];
    end
    result    = '0;
    dst_idx   = rd_idx;
    exec_fail = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  result = rs_val + rt_val;
          FN_SUB:  result = rs_val - rt_val;
          FN_AND:  result = rs_val & rt_val;
          FN_OR:   result = rs_val | rt_val;
          FN_NOR:  result = ~(rs_val | rt_val);
          FN_SLT:  result = ($signed(rs_val) < $signed(rt_val)) ? DATA_W'(1) : '0;
          FN_SLL:  result = (int'(shamt) >= DATA_W) ? '0 : (rt_val << shamt);
          FN_SRL:  result = (int'(shamt) >= DATA_W) ? '0 : (rt_val >> shamt);
          default: exec_fail = 1'b1;
        endcase
        // Shifts never read rs, so an unmapped rs code only matters for the ALU ops.
        if (rd_idx < 0 || rt_idx < 0) exec_fail = 1'b1;
        if (rs_idx < 0 && funct != FN_SLL && funct != FN_SRL) exec_fail = 1'b1;
      end
      OP_ADDI: begin
        dst_idx   = rt_idx;
        result    = rs_val + DATA_W'(imm_s);
        exec_fail = (rs_idx < 0) || (rt_idx < 0);
      end
      OP_ANDI: begin
        dst_idx   = rt_idx;
        result    = rs_val & DATA_W'(imm);
        exec_fail = (rs_idx < 0) || (rt_idx < 0);
      end
      OP_ORI: begin
        dst_idx   = rt_idx;
        result    = rs_val | DATA_W'(imm);
        exec_fail = (rs_idx < 0) || (rt_idx < 0);
      end
      default: exec_fail = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_instr_d  = s1_instr_q;
    out_valid_d = out_valid_q;
    fail_d      = fail_q;
    rf_d        = rf_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (commit) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b1;
      fail_d      = exec_fail;
      if (!exec_fail) begin
        for (int i = 0; i < NUM_REG; i++) begin
          if (dst_idx == i) rf_d[i] = result;
        end
      end
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_instr_d = instruction;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_instr_q  <= '0;
      out_valid_q <= 1'b0;
      fail_q      <= 1'b0;
      for (int i = 0; i < NUM_REG; i++) rf_q[i] <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_instr_q  <= s1_instr_d;
      out_valid_q <= out_valid_d;
      fail_q      <= fail_d;
      rf_q        <= rf_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign instruction_fail = fail_q;

  generate
    for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_out
      assign out_regs[gi*DATA_W +: DATA_W] = out_valid_q ? rf_q[gi] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_mips_pipe_core.sv
// Bench for mips_pipe_core: directed steps plus random traffic on a 16-bit/6-reg and a
// 32-bit/8-reg instance, both scored against a plain-arithmetic register-file model.
module tb_mips_pipe_core;

  localparam logic [29:0] MAP16 = {5'd16, 5'd31, 5'd23, 5'd8, 5'd18, 5'd17};
  localparam logic [39:0] MAP32 = {5'd10, 5'd9, MAP16};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [31:0]  instruction = '0;
  logic         in_ready16, out_valid16, fail16;
  logic [95:0]  regs16;
  logic         in_ready32, out_valid32, fail32;
  logic [255:0] regs32;

  mips_pipe_core #(.DATA_W(16), .NUM_REG(6), .REG_MAP(MAP16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .instruction(instruction), .out_valid(out_valid16), .out_ready(out_ready),
    .instruction_fail(fail16), .out_regs(regs16)
  );

  mips_pipe_core #(.DATA_W(32), .NUM_REG(8), .REG_MAP(MAP32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instruction(instruction), .out_valid(out_valid32), .out_ready(out_ready),
    .instruction_fail(fail32), .out_regs(regs32)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         fail;
    logic [255:0] regs;
  } exp_t;

  exp_t         q16[$];
  exp_t         q32[$];
  longint       mrf[2][8];
  logic [4:0]   rmap[8] = '{5'd17, 5'd18, 5'd8, 5'd23, 5'd31, 5'd16, 5'd9, 5'd10};
  int           checks = 0;
  int           failures = 0;
  bit           acc;
  logic [255:0] last16 = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic int mlk(input int k, input logic [4:0] c);
    int n = (k != 0) ? 8 : 6;
    for (int i = 0; i < n; i++) if (rmap[i] == c) return i;
    return -1;
  endfunction

  function automatic longint sgn(input longint x, input int w);
    return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
  endfunction

  // Executes one instruction on model instance k and returns the expected output.
  task automatic model_exec(input int k, input logic [31:0] ins, output exp_t e);
    int     w = (k != 0) ? 32 : 16;
    int     n = (k != 0) ? 8 : 6;
    longint mask = (longint'(1) << w) - 1;
    int     rs = mlk(k, ins[25:21]);
    int     rt = mlk(k, ins[20:16]);
    int     rd = mlk(k, ins[15:11]);
    int     sh = int'(ins[10:6]);
    longint a = (rs >= 0) ? mrf[k][rs] : 0;
    longint b = (rt >= 0) ? mrf[k][rt] : 0;
    longint r = 0;
    int     dst = -1;
    bit     bad = 0;
    case (ins[31:26])
      6'h00: begin
        dst = rd;
        bad = (rd < 0) || (rt < 0);
        case (ins[5:0])
          6'h20: begin r = a + b; bad = bad || (rs < 0); end
          6'h22: begin r = a - b; bad = bad || (rs < 0); end
          6'h24: begin r = a & b; bad = bad || (rs < 0); end
          6'h25: begin r = a | b; bad = bad || (rs < 0); end
          6'h27: begin r = ~(a | b); bad = bad || (rs < 0); end
          6'h2A: begin r = (sgn(a, w) < sgn(b, w)) ? 1 : 0; bad = bad || (rs < 0); end
          6'h00: r = (sh >= w) ? 0 : (b << sh);
          6'h02: r = (sh >= w) ? 0 : (b >> sh);
          default: bad = 1;
        endcase
      end
      6'h08: begin dst = rt; bad = (rs < 0) || (rt < 0); r = a + longint'($signed(ins[15:0])); end
      6'h0C: begin dst = rt; bad = (rs < 0) || (rt < 0); r = a & longint'(ins[15:0]); end
      6'h0D: begin dst = rt; bad = (rs < 0) || (rt < 0); r = a | longint'(ins[15:0]); end
      default: bad = 1;
    endcase
    if (!bad) mrf[k][dst] = r & mask;
    e.fail = bad;
    e.regs = '0;
    for (int i = 0; i < n; i++) e.regs = e.regs | (256'(mrf[k][i]) << (i * w));
  endtask

  // One clock: sample handshakes at the falling edge, score returns, model accepts.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready16;
    if (out_valid16 && out_ready) begin
      chk("out16_pending", 256'(q16.size() != 0), 256'(1));
      if (q16.size() != 0) begin
        e = q16.pop_front();
        chk("out16_regs", 256'(regs16), e.regs);
        chk("out16_fail", 256'(fail16), 256'(e.fail));
      end
      last16 = 256'(regs16);
    end
    if (out_valid32 && out_ready) begin
      chk("out32_pending", 256'(q32.size() != 0), 256'(1));
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("out32_regs", regs32, e.regs);
        chk("out32_fail", 256'(fail32), 256'(e.fail));
      end
    end
    if (in_valid && in_ready16) begin model_exec(0, instruction, e); q16.push_back(e); end
    if (in_valid && in_ready32) begin model_exec(1, instruction, e); q32.push_back(e); end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid = 1'b1;
    instruction = ins;
    cycle();
  endtask

  function automatic logic [4:0] rcode();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
    return rmap[$urandom_range(0, 5)];
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] fns[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};
    logic [5:0] ops[3] = '{6'h08, 6'h0C, 6'h0D};
    int s = int'($urandom_range(0, 11));
    if (s < 8) return r_ins(rcode(), rcode(), rcode(), 5'($urandom_range(0, 31)), fns[s]);
    if (s < 11) return i_ins(ops[s-8], rcode(), rcode(), 16'($urandom));
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  t3[3];
    logic [255:0] snap;
    int           idx;

    @(posedge clk); #1;
    chk("rst_in_ready", 256'(in_ready16), 256'(1));
    chk("rst_out_valid", 256'(out_valid16), 256'(0));
    chk("rst_fail", 256'(fail16), 256'(0));
    chk("rst_regs16", 256'(regs16), 256'(0));
    chk("rst_regs32", regs32, 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) dependent addi pair, results on consecutive cycles
    out_ready = 1'b1;
    issue(i_ins(6'h08, 5'd17, 5'd17, 16'd5));
    issue(i_ins(6'h08, 5'd17, 5'd18, 16'hFFFF));
    chk("t1_first_valid", 256'(out_valid16), 256'(1));
    chk("t1_first_reg0", 256'(regs16[15:0]), 256'(16'd5));
    in_valid = 1'b0;
    cycle();
    chk("t1_second_valid", 256'(out_valid16), 256'(1));
    chk("t1_second_regs", 256'(regs16[31:0]), 256'({16'd4, 16'd5}));
    cycle();

    // 2) sub and signed slt
    issue(r_ins(5'd18, 5'd17, 5'd8, 5'd0, 6'h22));
    issue(r_ins(5'd8, 5'd17, 5'd23, 5'd0, 6'h2A));
    chk("t2_sub", 256'(regs16[47:32]), 256'(16'hFFFF));
    in_valid = 1'b0;
    cycle();
    chk("t2_slt", 256'(regs16[63:48]), 256'(16'd1));
    cycle();

    // 3) back-pressure with three offered instructions
    t3[0] = i_ins(6'h0C, 5'd17, 5'd31, 16'h00F3);
    t3[1] = i_ins(6'h0D, 5'd18, 5'd16, 16'h8000);
    t3[2] = r_ins(5'd31, 5'd16, 5'd23, 5'd0, 6'h20);
    out_ready = 1'b0;
    idx = 0;
    snap = '0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) instruction = t3[idx];
      cycle();
      if (acc) idx++;
      if (c == 1) snap = 256'(regs16);
    end
    chk("t3_accepted_two", 256'(idx), 256'(2));
    chk("t3_in_ready_low", 256'(in_ready16), 256'(0));
    chk("t3_held_valid", 256'(out_valid16), 256'(1));
    chk("t3_regs_stable", 256'(regs16), snap);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 3 || q16.size() != 0); c++) begin
      in_valid = (idx < 3);
      if (idx < 3) instruction = t3[idx];
      cycle();
      if (acc) idx++;
    end
    chk("t3_all_accepted", 256'(idx), 256'(3));
    chk("t3_drained", 256'(q16.size()), 256'(0));
    chk("t3_final_reg3", last16[63:48], 256'(16'h8005));

    // 4) illegal opcode and unmapped destination
    snap = last16;
    issue(i_ins(6'h23, 5'd17, 5'd18, 16'd0));
    issue(r_ins(5'd17, 5'd18, 5'd3, 5'd0, 6'h20));
    chk("t4_fail_op", 256'(fail16), 256'(1));
    chk("t4_regs_op", 256'(regs16), snap);
    in_valid = 1'b0;
    cycle();
    chk("t4_fail_reg", 256'(fail16), 256'(1));
    chk("t4_regs_reg", 256'(regs16), snap);
    cycle();

    // 5) shifts, including an oversized shamt
    issue(r_ins(5'd0, 5'd17, 5'd31, 5'd4, 6'h00));
    issue(r_ins(5'd0, 5'd18, 5'd16, 5'd20, 6'h02));
    chk("t5_sll", 256'(regs16[79:64]), 256'(16'h0050));
    chk("t5_sll32", 256'(regs32[159:128]), 256'(32'h50));
    in_valid = 1'b0;
    cycle();
    chk("t5_srl", 256'(regs16[95:80]), 256'(16'h0000));
    cycle();

    // random traffic with random back-pressure on both widths
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      instruction = rand_ins();
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (q16.size() != 0 || q32.size() != 0); c++) cycle();
    chk("rand_drained16", 256'(q16.size()), 256'(0));
    chk("rand_drained32", 256'(q32.size()), 256'(0));

    // 6) asynchronous reset while stalled
    out_ready = 1'b0;
    issue(i_ins(6'h08, 5'd17, 5'd17, 16'd3));
    issue(i_ins(6'h08, 5'd18, 5'd18, 16'd9));
    in_valid = 1'b0;
    cycle();
    chk("t6_stalled", 256'(in_ready16), 256'(0));
    chk("t6_valid_before", 256'(out_valid16), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_cleared", 256'(out_valid16), 256'(0));
    chk("t6_regs_cleared", 256'(regs16), 256'(0));
    chk("t6_regs32_cleared", regs32, 256'(0));
    chk("t6_in_ready", 256'(in_ready16), 256'(1));
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) mrf[k][i] = 0;
    q16.delete();
    q32.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_in_ready_after", 256'(in_ready16), 256'(1));
    out_ready = 1'b1;
    issue(i_ins(6'h08, 5'd17, 5'd18, 16'd7));
    in_valid = 1'b0;
    cycle();
    chk("t6_regfile_zeroed", 256'(regs16), 256'({64'd0, 16'd7, 16'd0}));
    cycle();
    chk("t6_drained", 256'(q16.size() + q32.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
